// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Round-robin arbiter that shares one data-memory port among CORES load/store
// ports. One core's request is latched, the memory is driven for exactly one
// cycle, and the served core gets a one-cycle acknowledge in the cycle its
// read data is available. The cycle is IDLE -> ACCESS -> RESP, so there is one
// access every three cycles.
//
// Optional feature (macro DM_ARB_LOCK_EN): adds a per-core `lock` input. A core
// that holds lock high during its RESP cycle keeps exclusive ownership of the
// memory port until it drops lock. This is used for atomic
// load-compare-store sequences.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   req        in   [CORES]       per-core request, held until ack
//   we         in   [CORES]       per-core write enable, qualified by req
//   addr       in   [CORES*AW]    core i at [i*AW +: AW]
//   wdata      in   [CORES*DW]    core i at [i*DW +: DW]
//   lock       in   [CORES]       (DM_ARB_LOCK_EN only) hold ownership
//   ack        out  [CORES]       one-hot completion pulse
//   rdata      out  [DW]          read data, valid while ack is high
//   mem_en     out                memory access strobe
//   mem_we     out                memory write enable
//   mem_addr   out  [AW]          memory address
//   mem_wdata  out  [DW]          memory write data
//   mem_rdata  in   [DW]          memory read data, valid the cycle after mem_en
// -----------------------------------------------------------------------------
module dm_arbiter #(
    parameter int CORES      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CORES-1:0]            req,
    input  logic [CORES-1:0]            we,
    input  logic [CORES*ADDR_WIDTH-1:0] addr,
    input  logic [CORES*DATA_WIDTH-1:0] wdata,
`ifdef DM_ARB_LOCK_EN
    input  logic [CORES-1:0]            lock,
`endif
    output logic [CORES-1:0]            ack,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    input  logic [DATA_WIDTH-1:0]       mem_rdata
);

    localparam int IDX_W = $clog2(CORES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [IDX_W-1:0]        r_ptr;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;

    logic [IDX_W-1:0]        w_base;
    logic [IDX_W-1:0]        w_rr_idx;
    logic                    w_rr_valid;
    logic [IDX_W-1:0]        w_grant_idx;
    logic                    w_grant_ok;
    logic                    w_take;

    logic [ADDR_WIDTH-1:0]   w_addr_arr  [CORES];
    logic [DATA_WIDTH-1:0]   w_wdata_arr [CORES];

    // Successor in the rotation, wrapping CORES-1 -> 0 (CORES need not be a
    // power of two).
    function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(CORES - 1)) begin
            return '0;
        end
        return i + IDX_W'(1);
    endfunction

    // Unpack the flattened per-core buses and decode the one-hot ack.
    generate
        for (genvar gi = 0; gi < CORES; gi++) begin : g_core
            assign w_addr_arr[gi]  = addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata_arr[gi] = wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign ack[gi]         = (r_state == RESP) && (r_idx == IDX_W'(gi));
        end
    endgenerate

    // First requesting core at or after w_base, scanning with wrap-around.
    always_comb begin
        logic [IDX_W-1:0] cand;
        w_rr_valid = 1'b0;
        w_rr_idx   = w_base;
        cand       = w_base;
        for (int k = 0; k < CORES; k++) begin
            if (!w_rr_valid && req[cand]) begin
                w_rr_valid = 1'b1;
                w_rr_idx   = cand;
            end
            cand = f_next(cand);
        end
    end

`ifdef DM_ARB_LOCK_EN
    logic r_locked;
    logic w_lock_hold;
    logic w_unlock;

    // While locked, only the owner may be granted. When the owner's lock is
    // seen low in IDLE, arbitration restarts just past the owner in the same
    // cycle, since the pointer was left parked on it.
    assign w_lock_hold = r_locked && lock[r_idx];
    assign w_unlock    = r_locked && !lock[r_idx];
    assign w_base      = w_unlock ? f_next(r_idx) : r_ptr;
    assign w_grant_ok  = w_lock_hold ? req[r_idx] : w_rr_valid;
    assign w_grant_idx = w_lock_hold ? r_idx : w_rr_idx;
`else
    assign w_base      = r_ptr;
    assign w_grant_ok  = w_rr_valid;
    assign w_grant_idx = w_rr_idx;
`endif

    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_ok) begin
                    w_take       = 1'b1;
                    w_state_next = ACCESS;
                end
            end
            ACCESS:  w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_idx    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
`ifdef DM_ARB_LOCK_EN
            r_locked <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            // Inputs are captured once at grant; later changes by the core
            // cannot disturb the access in flight.
            if (w_take) begin
                r_idx   <= w_grant_idx;
                r_we    <= we[w_grant_idx];
                r_addr  <= w_addr_arr[w_grant_idx];
                r_wdata <= w_wdata_arr[w_grant_idx];
            end
`ifdef DM_ARB_LOCK_EN
            if (r_state == IDLE && w_unlock) begin
                r_locked <= 1'b0;
                r_ptr    <= f_next(r_idx);
            end
            if (r_state == RESP) begin
                if (lock[r_idx]) begin
                    r_locked <= 1'b1;
                end else begin
                    r_locked <= 1'b0;
                    r_ptr    <= f_next(r_idx);
                end
            end
`else
            if (r_state == RESP) begin
                r_ptr <= f_next(r_idx);
            end
`endif
        end
    end

    // The memory's own output register supplies the read data during RESP,
    // exactly when ack is high, so it is forwarded rather than re-registered
    // (re-registering would land it one cycle after ack). Zero otherwise, so
    // reset clears it immediately.
    assign rdata     = (r_state == RESP) ? mem_rdata : '0;
    assign mem_en    = (r_state == ACCESS);
    assign mem_we    = (r_state == ACCESS) && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

    localparam int CORES = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic                 clk;
    logic                 rst;
    logic [CORES-1:0]     req;
    logic [CORES-1:0]     we;
    logic [CORES*AW-1:0]  addr;
    logic [CORES*DW-1:0]  wdata;
`ifdef DM_ARB_LOCK_EN
    logic [CORES-1:0]     lock;
`endif
    logic [CORES-1:0]     ack;
    logic [DW-1:0]        rdata;
    logic                 mem_en;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem_rdata;

    dm_arbiter #(.CORES(CORES), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
`ifdef DM_ARB_LOCK_EN
        .lock      (lock),
`endif
        .ack       (ack),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 1-cycle synchronous read, read-before-write, plus a
    // preload port used only by the bench.
    logic [DW-1:0] mem [0:63];
    logic          pre_en;
    logic [5:0]    pre_addr;
    logic [DW-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[5:0]];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard: expected acks in order of service.
    typedef struct {
        int          core;
        logic        chk;
        logic [31:0] rdata;
    } sb_t;
    sb_t sbq[$];

    bit spacing_en = 1'b0;
    int last_ack   = -1;

    always @(negedge clk) begin
        if (!rst && ack != '0) begin
            check("ack_onehot", 64'($onehot(ack)), 64'd1);
            if (sbq.size() == 0) begin
                check("unexpected_ack", 64'(ack), 64'd0);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                $display("ack=%b rdata=%h (expect core %0d)", ack, rdata, e.core);
                check("ack_core", 64'(ack), 64'(4'b0001 << e.core));
                if (e.chk) check("rdata", 64'(rdata), 64'(e.rdata));
            end
            if (spacing_en) begin
                if (last_ack >= 0) check("ack_spacing", 64'(cyc - last_ack), 64'd3);
                last_ack = cyc;
            end
        end
    end

    task automatic preload(input logic [5:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic set_core(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[c]             = w;
        addr[c*AW +: AW]  = a;
        wdata[c*DW +: DW] = d;
    endtask

    // Each core keeps req high until it has been acked remain[c] times.
    int remain [CORES];

    task automatic drive_until(input string name, input int budget);
        int t;
        int left;
        t = 0;
        left = 1;
        while (left != 0 && t < budget) begin
            @(negedge clk);
            t++;
            left = 0;
            for (int c = 0; c < CORES; c++) begin
                if (ack[c] && remain[c] > 0) begin
                    remain[c]--;
                    if (remain[c] == 0) begin
                        req[c] = 1'b0;
`ifdef DM_ARB_LOCK_EN
                        lock[c] = 1'b0;
`endif
                    end
                end
                left += remain[c];
            end
        end
        check(name, 64'(left), 64'd0);
        for (int c = 0; c < CORES; c++) begin
            remain[c] = 0;
            req[c]    = 1'b0;
        end
    endtask

    task automatic push(input int c, input logic chk, input logic [31:0] d);
        sb_t e;
        e.core = c; e.chk = chk; e.rdata = d;
        sbq.push_back(e);
    endtask

    typedef struct {
        int          core;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_ack;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t tab [6];

    initial begin
        tab[0] = '{core: 2, we: 1'b0, addr: 32'd5,  wdata: 32'd0,      exp_ack: 4'b0100, exp_rdata: 32'd9};
        tab[1] = '{core: 0, we: 1'b1, addr: 32'd3,  wdata: 32'd11,     exp_ack: 4'b0001, exp_rdata: 32'd0};
        tab[2] = '{core: 1, we: 1'b0, addr: 32'd3,  wdata: 32'd0,      exp_ack: 4'b0010, exp_rdata: 32'd11};
        tab[3] = '{core: 3, we: 1'b1, addr: 32'd10, wdata: 32'hABCD,   exp_ack: 4'b1000, exp_rdata: 32'd0};
        tab[4] = '{core: 3, we: 1'b0, addr: 32'd10, wdata: 32'h5555,   exp_ack: 4'b1000, exp_rdata: 32'hABCD};
        tab[5] = '{core: 0, we: 1'b0, addr: 32'd5,  wdata: 32'd0,      exp_ack: 4'b0001, exp_rdata: 32'd9};

        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
`ifdef DM_ARB_LOCK_EN
        lock = '0;
`endif
        for (int c = 0; c < CORES; c++) remain[c] = 0;
        preload(6'd5, 32'd9);
        preload(6'd7, 32'd6);

        // Reset state
        check("rst_ack",    64'(ack),       64'd0);
        check("rst_rdata",  64'(rdata),     64'd0);
        check("rst_mem_en", 64'(mem_en),    64'd0);
        check("rst_mem_we", 64'(mem_we),    64'd0);
        check("rst_addr",   64'(mem_addr),  64'd0);
        check("rst_wdata",  64'(mem_wdata), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table of single accesses with exact latency checks
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req[tab[i].core] = 1'b1;
            set_core(tab[i].core, tab[i].we, tab[i].addr, tab[i].wdata);
            push(tab[i].core, !tab[i].we, tab[i].exp_rdata);
            @(negedge clk);
            check("access_en",   64'(mem_en),   64'd1);
            check("access_addr", 64'(mem_addr), 64'(tab[i].addr));
            check("access_we",   64'(mem_we),   64'(tab[i].we));
            if (tab[i].we) check("access_wdata", 64'(mem_wdata), 64'(tab[i].wdata));
            check("access_noack", 64'(ack), 64'd0);
            @(negedge clk);
            check("resp_ack", 64'(ack),    64'(tab[i].exp_ack));
            check("resp_en",  64'(mem_en), 64'd0);
            if (tab[i].we) check("mem_written", 64'(mem[tab[i].addr[5:0]]), 64'(tab[i].wdata));
            req[tab[i].core] = 1'b0;
            we = '0;
        end

        // All cores from reset: order 0,1,2,3,0,1,2,3 with 3-cycle spacing
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < CORES; c++) begin
            set_core(c, 1'b0, AW'(c), '0);
            remain[c] = 2;
        end
        for (int r = 0; r < 2; r++) for (int c = 0; c < CORES; c++) push(c, 1'b0, '0);
        spacing_en = 1'b1; last_ack = -1;
        req = '1;
        drive_until("all_cores_done", 40);
        spacing_en = 1'b0;

        // Rotation: core 1 re-requests, core 3 once -> 1,3,1
        @(negedge clk);
        remain[1] = 2; remain[3] = 1;
        push(1, 1'b0, '0); push(3, 1'b0, '0); push(1, 1'b0, '0);
        spacing_en = 1'b1; last_ack = -1;
        req[1] = 1'b1; req[3] = 1'b1;
        drive_until("rotation_done", 30);
        spacing_en = 1'b0;

        // Reset during the ACCESS of a write to addr 7
        @(negedge clk);
        req[0] = 1'b1;
        set_core(0, 1'b1, 32'd7, 32'd99);
        @(negedge clk);
        check("wr_access_en", 64'(mem_en), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_en", 64'(mem_en), 64'd0);
        check("rst_async_we", 64'(mem_we), 64'd0);
        check("rst_async_ack", 64'(ack), 64'd0);
        req = '0; we = '0;
        @(negedge clk);
        check("rst_no_ack", 64'(ack), 64'd0);
        rst = 1'b0;
        check("mem7_kept", 64'(mem[7]), 64'd6);
        // Pointer back at 0: core 0 before core 3
        remain[0] = 1; remain[3] = 1;
        set_core(3, 1'b0, 32'd7, '0);
        push(0, 1'b1, 32'd6); push(3, 1'b1, 32'd6);
        set_core(0, 1'b0, 32'd7, '0);
        req[0] = 1'b1; req[3] = 1'b1;
        drive_until("ptr_reset_done", 20);

`ifdef DM_ARB_LOCK_EN
        // Core 0 holds lock across two accesses while core 2 waits
        @(negedge clk);
        set_core(0, 1'b0, 32'd5, '0);
        set_core(2, 1'b0, 32'd7, '0);
        remain[0] = 2; remain[2] = 1;
        push(0, 1'b1, 32'd9); push(0, 1'b1, 32'd9); push(2, 1'b1, 32'd6);
        lock[0] = 1'b1;
        req[0] = 1'b1; req[2] = 1'b1;
        drive_until("lock_done", 30);
`endif

        repeat (5) @(negedge clk);
        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
